// File: rtl/jcnt_pkg.sv
// Shared constants and types for the jcnt_gen Johnson/ring sequencer.
package jcnt_pkg;

  localparam logic MODE_JOHNSON = 1'b0;
  localparam logic MODE_RING    = 1'b1;

  localparam logic DIR_UP = 1'b0;
  localparam logic DIR_DN = 1'b1;

  // Per-cycle action, resolved in priority order below reset.
  typedef enum logic [1:0] {
    ActMode,
    ActLoad,
    ActStep,
    ActHold
  } act_e;

endpackage

// File: rtl/jcnt_decode.sv
// Combinational legality check and phase decode of a Johnson or one-hot ring state.
module jcnt_decode
  import jcnt_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0]            value,
  input  logic                        mode,
  output logic                        legal,
  output logic [$clog2(2*WIDTH)-1:0]  phase
);

  localparam int unsigned PHASE_W = $clog2(2*WIDTH);

  logic [WIDTH-1:0] inv;
  int unsigned      ones;
  int unsigned      idx;

  always_comb begin
    ones = 0;
    idx  = 0;
    inv  = ~value;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      ones = ones + 32'(value[i]);
      if (value[i]) idx = i;
    end

    legal = 1'b0;
    phase = '0;
    if (mode == MODE_RING) begin
      legal = (ones == 1);
      phase = PHASE_W'(idx);
    end else begin
      // Low-aligned ones have no carry overlap with value+1; high-aligned is the same test on ~value.
      legal = ((value & (value + WIDTH'(1))) == '0) || ((inv & (inv + WIDTH'(1))) == '0);
      if (value == '0) begin
        phase = '0;
      end else if (value[0]) begin
        phase = PHASE_W'(ones);
      end else begin
        phase = PHASE_W'(2 * WIDTH - ones);
      end
    end
  end

endmodule

// File: rtl/jcnt_gen.sv
// Parametrised Johnson / one-hot ring counter with direction, enable, validated load,
// registered phase index and one-cycle wrap pulse.
module jcnt_gen
  import jcnt_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic                        dir,
  input  logic                        mode,
  input  logic                        load,
  input  logic [WIDTH-1:0]            load_val,
  output logic [WIDTH-1:0]            q,
  output logic [$clog2(2*WIDTH)-1:0]  phase,
  output logic                        wrap,
  output logic                        load_err
);

  localparam int unsigned PHASE_W = $clog2(2*WIDTH);
  localparam logic [PHASE_W-1:0] JohnLast = PHASE_W'(2 * WIDTH - 1);
  localparam logic [PHASE_W-1:0] RingLast = PHASE_W'(WIDTH - 1);

  logic               mode_q, mode_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic               wrap_q, wrap_d;
  logic               load_err_q, load_err_d;

  logic               ld_legal;
  logic [PHASE_W-1:0] ld_phase;
  logic [PHASE_W-1:0] last;
  act_e               act;

  // Load legality is judged against the mode currently in force.
  jcnt_decode #(
    .WIDTH (WIDTH)
  ) u_ld_decode (
    .value (load_val),
    .mode  (mode_q),
    .legal (ld_legal),
    .phase (ld_phase)
  );

  always_comb begin
    mode_d     = mode_q;
    q_d        = q_q;
    phase_d    = phase_q;
    wrap_d     = 1'b0;
    load_err_d = 1'b0;
    last       = (mode_q == MODE_RING) ? RingLast : JohnLast;

    if (mode != mode_q) begin
      act = ActMode;
    end else if (load) begin
      act = ActLoad;
    end else if (en) begin
      act = ActStep;
    end else begin
      act = ActHold;
    end

    unique case (act)
      ActMode: begin
        mode_d  = mode;
        q_d     = (mode == MODE_RING) ? WIDTH'(1) : '0;
        phase_d = '0;
      end
      ActLoad: begin
        if (ld_legal) begin
          q_d     = load_val;
          phase_d = ld_phase;
        end else begin
          load_err_d = 1'b1;
        end
      end
      ActStep: begin
        if (dir == DIR_UP) begin
          q_d = (mode_q == MODE_RING) ? {q_q[WIDTH-2:0], q_q[WIDTH-1]}
                                      : {q_q[WIDTH-2:0], ~q_q[WIDTH-1]};
          if (phase_q == last) begin
            phase_d = '0;
            wrap_d  = 1'b1;
          end else begin
            phase_d = phase_q + PHASE_W'(1);
          end
        end else begin
          q_d = (mode_q == MODE_RING) ? {q_q[0], q_q[WIDTH-1:1]}
                                      : {~q_q[0], q_q[WIDTH-1:1]};
          if (phase_q == '0) begin
            phase_d = last;
            wrap_d  = 1'b1;
          end else begin
            phase_d = phase_q - PHASE_W'(1);
          end
        end
      end
      ActHold: begin
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q     <= MODE_JOHNSON;
      q_q        <= '0;
      phase_q    <= '0;
      wrap_q     <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      mode_q     <= mode_d;
      q_q        <= q_d;
      phase_q    <= phase_d;
      wrap_q     <= wrap_d;
      load_err_q <= load_err_d;
    end
  end

  assign q        = q_q;
  assign phase    = phase_q;
  assign wrap     = wrap_q;
  assign load_err = load_err_q;

endmodule

// File: tb/tb_jcnt_gen.sv
// Directed scoreboard bench for jcnt_gen at WIDTH=4; jcnt_decode also checks q stays legal.
module tb_jcnt_gen;

  logic       clk = 1'b0;
  logic       rst, en, dir, mode, load;
  logic [3:0] load_val;
  logic [3:0] q;
  logic [2:0] phase;
  logic       wrap, load_err;

  logic       ref_mode;
  logic       ref_legal;
  logic [2:0] ref_phase;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string      tag;
    logic [3:0] q;
    logic [2:0] ph;
    logic       wr;
    logic       er;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  jcnt_gen #(
    .WIDTH (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .dir      (dir),
    .mode     (mode),
    .load     (load),
    .load_val (load_val),
    .q        (q),
    .phase    (phase),
    .wrap     (wrap),
    .load_err (load_err)
  );

  jcnt_decode #(
    .WIDTH (4)
  ) u_ref (
    .value (q),
    .mode  (ref_mode),
    .legal (ref_legal),
    .phase (ref_phase)
  );

  task automatic check_out();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_empty: got 0 entries want 1");
      return;
    end
    e = sb.pop_front();
    checks++;
    assert (q === e.q) else begin
      errors++;
      $error("FAIL %s q: got %b want %b", e.tag, q, e.q);
    end
    checks++;
    assert (phase === e.ph) else begin
      errors++;
      $error("FAIL %s phase: got %0d want %0d", e.tag, phase, e.ph);
    end
    checks++;
    assert (wrap === e.wr) else begin
      errors++;
      $error("FAIL %s wrap: got %b want %b", e.tag, wrap, e.wr);
    end
    checks++;
    assert (load_err === e.er) else begin
      errors++;
      $error("FAIL %s load_err: got %b want %b", e.tag, load_err, e.er);
    end
    checks++;
    assert (ref_legal === 1'b1) else begin
      errors++;
      $error("FAIL %s legal_state: got %b want 1 (q=%b)", e.tag, ref_legal, q);
    end
    checks++;
    assert (phase === ref_phase) else begin
      errors++;
      $error("FAIL %s phase_decode: got %0d want %0d", e.tag, phase, ref_phase);
    end
  endtask

  // One clock: drive inputs, queue the expected registered outputs, compare after the edge.
  task automatic cyc(input string tag, input logic r, input logic e, input logic d,
                     input logic m, input logic l, input logic [3:0] lv,
                     input logic [3:0] eq, input logic [2:0] eph, input logic ew,
                     input logic ee);
    exp_t x;
    rst      = r;
    en       = e;
    dir      = d;
    mode     = m;
    load     = l;
    load_val = lv;
    x.tag = tag;
    x.q   = eq;
    x.ph  = eph;
    x.wr  = ew;
    x.er  = ee;
    sb.push_back(x);
    @(posedge clk);
    ref_mode = r ? 1'b0 : m;
    #1;
    check_out();
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; dir = 1'b0; mode = 1'b0; load = 1'b0; load_val = 4'b0000;
    ref_mode = 1'b0;
    #2;

    // Johnson up through a full wrap
    cyc("rst0",   1, 0, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, 0);
    cyc("jup1",   0, 1, 0, 0, 0, 4'b0000, 4'b0001, 1, 0, 0);
    cyc("jup2",   0, 1, 0, 0, 0, 4'b0000, 4'b0011, 2, 0, 0);
    cyc("jup3",   0, 1, 0, 0, 0, 4'b0000, 4'b0111, 3, 0, 0);
    cyc("jup4",   0, 1, 0, 0, 0, 4'b0000, 4'b1111, 4, 0, 0);
    cyc("jup5",   0, 1, 0, 0, 0, 4'b0000, 4'b1110, 5, 0, 0);
    cyc("jup6",   0, 1, 0, 0, 0, 4'b0000, 4'b1100, 6, 0, 0);
    cyc("jup7",   0, 1, 0, 0, 0, 4'b0000, 4'b1000, 7, 0, 0);
    cyc("jup8",   0, 1, 0, 0, 0, 4'b0000, 4'b0000, 0, 1, 0);
    cyc("jup9",   0, 1, 0, 0, 0, 4'b0000, 4'b0001, 1, 0, 0);

    // Johnson down from reset
    cyc("rst1",   1, 1, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, 0);
    cyc("jdn1",   0, 1, 1, 0, 0, 4'b0000, 4'b1000, 7, 1, 0);
    cyc("jdn2",   0, 1, 1, 0, 0, 4'b0000, 4'b1100, 6, 0, 0);
    cyc("jdn3",   0, 1, 1, 0, 0, 4'b0000, 4'b1110, 5, 0, 0);
    cyc("jdn4",   0, 1, 1, 0, 0, 4'b0000, 4'b1111, 4, 0, 0);
    cyc("jdn5",   0, 1, 1, 0, 0, 4'b0000, 4'b0111, 3, 0, 0);

    // Ring mode seed, up wrap, down wrap
    cyc("rst2",   1, 0, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, 0);
    cyc("rseed",  0, 0, 0, 1, 0, 4'b0000, 4'b0001, 0, 0, 0);
    cyc("rup1",   0, 1, 0, 1, 0, 4'b0000, 4'b0010, 1, 0, 0);
    cyc("rup2",   0, 1, 0, 1, 0, 4'b0000, 4'b0100, 2, 0, 0);
    cyc("rup3",   0, 1, 0, 1, 0, 4'b0000, 4'b1000, 3, 0, 0);
    cyc("rup4",   0, 1, 0, 1, 0, 4'b0000, 4'b0001, 0, 1, 0);
    cyc("rdn1",   0, 1, 1, 1, 0, 4'b0000, 4'b1000, 3, 1, 0);
    cyc("rdn2",   0, 1, 1, 1, 0, 4'b0000, 4'b0100, 2, 0, 0);

    // Back to Johnson (en ignored on mode change), then loads with en=1
    cyc("jseed",  0, 1, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, 0);
    cyc("jld1100",0, 1, 0, 0, 1, 4'b1100, 4'b1100, 6, 0, 0);
    cyc("jld0101",0, 1, 0, 0, 1, 4'b0101, 4'b1100, 6, 0, 1);
    cyc("jstep",  0, 1, 0, 0, 0, 4'b0000, 4'b1000, 7, 0, 0);
    cyc("jld0011",0, 1, 0, 0, 1, 4'b0011, 4'b0011, 2, 0, 0);
    cyc("jld1111",0, 1, 0, 0, 1, 4'b1111, 4'b1111, 4, 0, 0);
    cyc("jld1000",0, 0, 0, 0, 1, 4'b1000, 4'b1000, 7, 0, 0);
    cyc("jld1010",0, 0, 0, 0, 1, 4'b1010, 4'b1000, 7, 0, 1);
    cyc("jld0000",0, 1, 0, 0, 1, 4'b0000, 4'b0000, 0, 0, 0);

    // Ring loads
    cyc("rseed2", 0, 1, 0, 1, 1, 4'b0100, 4'b0001, 0, 0, 0);
    cyc("rld0110",0, 1, 0, 1, 1, 4'b0110, 4'b0001, 0, 0, 1);
    cyc("rld0100",0, 1, 0, 1, 1, 4'b0100, 4'b0100, 2, 0, 0);
    cyc("rld0000",0, 0, 0, 1, 1, 4'b0000, 4'b0100, 2, 0, 1);
    cyc("rld1111",0, 1, 0, 1, 1, 4'b1111, 4'b0100, 2, 0, 1);
    cyc("rld1000",0, 1, 1, 1, 1, 4'b1000, 4'b1000, 3, 0, 0);

    // Simultaneous events
    cyc("rstall", 1, 1, 0, 1, 1, 4'b0010, 4'b0000, 0, 0, 0);
    cyc("seedwin",0, 1, 0, 1, 1, 4'b0110, 4'b0001, 0, 0, 0);
    cyc("rup5",   0, 1, 0, 1, 0, 4'b0000, 4'b0010, 1, 0, 0);
    cyc("rup6",   0, 1, 0, 1, 0, 4'b0000, 4'b0100, 2, 0, 0);
    cyc("rup7",   0, 1, 0, 1, 0, 4'b0000, 4'b1000, 3, 0, 0);
    cyc("rup8",   0, 1, 0, 1, 0, 4'b0000, 4'b0001, 0, 1, 0);
    cyc("hold1",  0, 0, 0, 1, 0, 4'b0000, 4'b0001, 0, 0, 0);
    cyc("hold2",  0, 0, 1, 1, 0, 4'b0000, 4'b0001, 0, 0, 0);
    cyc("jseed2", 0, 0, 0, 0, 1, 4'b0011, 4'b0000, 0, 0, 0);
    cyc("jhold",  0, 0, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, 0);

    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL scoreboard_drain: got %0d entries want 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/jcnt_gen.md
Name: jcnt_gen

Overview:
- Parametrised successor to the 4-bit Johnson counter `jcnt`.
- Generalised to WIDTH bits.
- Two run-time modes: Johnson (twisted ring) and one-hot ring.
- Adds direction control, clock enable, validated synchronous load, a decoded phase index and a one-cycle wrap pulse.
- Used as a sequencer and phase generator for downstream timing logic.

Parameters:
- WIDTH, 4, counter width in bits; must be >= 2.
- PHASE_W, $clog2(2*WIDTH), localparam; width of the phase output.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  step enable; when 1, the counter advances one state per clock.
- dir  in  1  0 = up, 1 = down.
- mode  in  1  0 = Johnson, 1 = ring.
- load  in  1  synchronous load request.
- load_val  in  WIDTH  value to load; must be a legal state for the current mode.
- q  out  WIDTH  registered counter state.
- phase  out  PHASE_W  registered phase index of q.
- wrap  out  1  registered one-cycle pulse when the sequence wraps.
- load_err  out  1  registered one-cycle pulse when a load is rejected.

Behaviour:
- Priority per cycle: rst > mode change > load > en step > hold.

Reset:
- Applies to the Johnson state only; the ring seed is written on the first clock after reset, via the mode-change rule below.
- Outputs: q = 0, phase = 0, wrap = 0, load_err = 0.
- Internal mode_q = 0 (Johnson).

Mode change (mode != mode_q):
- mode_q <= mode.
- q <= seed of the new mode: Johnson 0…0; ring 0…01.
- phase <= 0, wrap <= 0, load_err <= 0.
- load and en are ignored that cycle.

Johnson step:
- Up: q <= {q[W-2:0], ~q[W-1]}. For W=4 the sequence is 0000, 0001, 0011, 0111, 1111, 1110, 1100, 1000, then repeats.
- Down: q <= {~q[0], q[W-1:1]}, giving the reverse sequence.
- 2W states; phase runs 0 … 2W-1.

Ring step:
- Up: rotate left, q <= {q[W-2:0], q[W-1]}.
- Down: rotate right.
- W states; phase is the index of the set bit, 0 … W-1.

Phase update:
- On a step: up phase+1 modulo N; down phase-1 modulo N.
- N = 2W (Johnson) or W (ring).

Wrap:
- wrap <= 1 for exactly the one cycle following a step from phase N-1 to 0 (up), or from 0 to N-1 (down).
- Otherwise wrap <= 0.
- Hold, load and mode change all give wrap = 0.

Load:
- Legality per mode:
  - Johnson legal: low-aligned ones (0…01…1, including all-zero) or high-aligned ones (1…10…0, including all-ones).
  - Ring legal: exactly one bit set.
- Legal value: q <= load_val, phase <= decode(load_val), load_err <= 0.
- Illegal value: q and phase unchanged, load_err <= 1 for one cycle.
- Load overrides en in the same cycle; no step occurs.
- Johnson phase decode:
  - q == 0: phase 0.
  - q[0] == 1: phase = popcount(q).
  - otherwise: phase = 2W - popcount(q).
- Ring phase decode: phase = index of the set bit.

Hold and reset timing:
- en = 0 with no load: q and phase hold; wrap and load_err go to 0.
- rst asserted mid-sequence: the Johnson reset state appears on the next edge, whatever en, load or mode are doing.

Invariant:
- q is always a legal state for mode_q.
- phase always equals decode(q).

Decomposition:
- Package jcnt_pkg:
  - Mode constants MODE_JOHNSON = 1'b0, MODE_RING = 1'b1.
  - Direction constants DIR_UP = 1'b0, DIR_DN = 1'b1.
- Sub-module jcnt_decode: combinational, parametrised by WIDTH.
  - Inputs: value, mode.
  - Outputs: legal, phase.
  - Instanced on the load path; the bench reuses it as the reference checker on q.

Test Plan (WIDTH=4):
1. Johnson up: rst for 1 cycle, then mode=0, en=1, dir=0 for 9 cycles.
   - q = 0001, 0011, 0111, 1111, 1110, 1100, 1000, 0000, 0001.
   - phase = 1 … 7, 0, 1.
   - wrap = 1 only in the cycle q returns to 0000.
2. Johnson down from 0000:
   - q = 1000, 1100, 1110, 1111, 0111; phase = 7, 6, 5, 4, 3.
   - wrap = 1 in the cycle q = 1000.
3. Ring mode: after reset raise mode=1.
   - Next edge: q = 0001, phase = 0, wrap = 0.
   - en=1, dir=0 for 4 cycles: q = 0010, 0100, 1000, 0001; wrap = 1 with the final 0001.
4. Load, Johnson mode (en=1 throughout):
   - load_val = 1100 → q = 1100, phase = 6, no step that cycle.
   - load_val = 0101 → load_err = 1 for one cycle, q stays 1100.
5. Load, ring mode: load_val = 0110 → load_err = 1, q unchanged.
6. Simultaneous events:
   - rst=1 with load=1 and en=1 → q = 0000, phase = 0.
   - Toggling mode with load=1 → seed wins and load_err = 0.
   - en=0 → q holds and wrap stays 0.
